// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// a one-entry skid buffer, flush/bubble insertion and a saturating counter
// of stalled cycles. Control and data bundles are carried opaquely.
module pipe_stage_reg #(
    parameter int                CTRL_W      = 16,
    parameter int                DATA_W      = 101,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              consume;

    // Handshake flags are pure decodes of the state register, so the
    // upstream ready never depends on downstream ready combinationally.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign stall_cnt = cnt;

    // Occupancy state machine: main register feeds the outputs, the skid
    // register catches the one entry accepted while downstream stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            main_ctrl <= BUBBLE_CTRL;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // Data registers keep their contents; only control is bubbled.
            state     <= EMPTY;
            main_ctrl <= BUBBLE_CTRL;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        state     <= HALF;
                    end else begin
                        main_ctrl <= BUBBLE_CTRL;
                    end
                end
                HALF: begin
                    if (accept && consume) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (accept) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        state     <= FULL;
                    end else if (consume) begin
                        main_ctrl <= BUBBLE_CTRL;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // No accept possible here, so the skid entry always
                    // moves to main before any newer input.
                    if (consume) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        state     <= HALF;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_ctrl <= BUBBLE_CTRL;
                end
            endcase
        end
    end

    // Saturating count of cycles where a valid entry is held back by
    // downstream; flush cycles are not counted and only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// a table of explicit per-cycle expectations for back-pressure and flush,
// and hand-written sequences for reset, streaming, saturation and drain.
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 101;
    localparam int NW = 4;
    localparam int CNT_SAT = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W      (CW),
        .DATA_W      (DW),
        .BUBBLE_CTRL ({CW{1'b0}}),
        .CNT_W       (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic          iv;
        logic [CW-1:0] c;
        logic          ordy;
        logic          fl;
        logic          e_ov;
        logic [CW-1:0] e_c;
        logic          e_ir;
        logic [NW-1:0] e_cnt;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    ent_t          sb[$];
    logic [DW-1:0] last_data = '0;
    int            mcnt = 0;
    logic [DW-1:0] drv_data;
    vec_t          tbl[13];

    function automatic logic [DW-1:0] rnd_data();
        return {5'($urandom()), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, advance the reference queue at the edge, then compare.
    task automatic step(input logic r, input logic iv, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        int   sz;
        logic cons;
        logic acc;
        ent_t e;
        drv_data  = rnd_data();
        rst       = r;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = drv_data;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        if (!r) begin
            sb.delete();
            mcnt      = 0;
            last_data = '0;
        end else begin
            sz   = sb.size();
            cons = (sz > 0) && ordy;
            acc  = iv && (sz < 2);
            if ((sz > 0) && !ordy && !fl && (mcnt != CNT_SAT)) mcnt++;
            if (fl) begin
                sb.delete();
            end else begin
                if (cons) void'(sb.pop_front());
                if (acc) begin
                    e.c = c;
                    e.d = drv_data;
                    sb.push_back(e);
                end
            end
            if (sb.size() > 0) last_data = sb[0].d;
        end
        @(negedge clk);
        chk("sb_out_valid", 128'(out_valid), 128'(sb.size() > 0));
        chk("sb_in_ready", 128'(in_ready), 128'(sb.size() < 2));
        chk("sb_out_ctrl", 128'(out_ctrl), (sb.size() > 0) ? 128'(sb[0].c) : 128'(0));
        chk("sb_out_data", 128'(out_data), 128'(last_data));
        chk("sb_stall_cnt", 128'(stall_cnt), 128'(mcnt));
    endtask

    logic [DW-1:0] sat_data;

    initial begin
        //          iv    ctrl     ordy  fl    ov    ctrl     ir    cnt
        tbl[0]  = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 4'd0};
        tbl[1]  = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 4'd1};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 4'd2};
        tbl[3]  = '{1'b1, 16'h000C, 1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 4'd3};
        tbl[4]  = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 16'h000B, 1'b1, 4'd3};
        tbl[5]  = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 16'h000C, 1'b1, 4'd3};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd3};
        tbl[7]  = '{1'b1, 16'h000D, 1'b0, 1'b0, 1'b1, 16'h000D, 1'b1, 4'd3};
        tbl[8]  = '{1'b1, 16'h000E, 1'b0, 1'b0, 1'b1, 16'h000D, 1'b0, 4'd4};
        tbl[9]  = '{1'b1, 16'h000F, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd4};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd4};
        tbl[11] = '{1'b1, 16'h0011, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 4'd4};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd4};

        // Reset held two cycles with a valid all-ones input presented.
        step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rel_out_valid", 128'(out_valid), 128'(0));

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, CW'(i), 1'b1, 1'b0);
            chk($sformatf("stream%0d_ctrl", i), 128'(out_ctrl), 128'(i));
            chk($sformatf("stream%0d_ready", i), 128'(in_ready), 128'(1));
            chk($sformatf("stream%0d_valid", i), 128'(out_valid), 128'(1));
        end
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Back-pressure and flush table, from a clean reset.
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            step(1'b1, tbl[i].iv, tbl[i].c, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_ctrl", i), 128'(out_ctrl), 128'(tbl[i].e_c));
            chk($sformatf("tbl%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_stall_cnt", i), 128'(stall_cnt), 128'(tbl[i].e_cnt));
        end

        // Counter saturation, then bubble drain of the single held entry.
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0);
        sat_data = drv_data;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk("sat_stall_cnt", 128'(stall_cnt), 128'(CNT_SAT));
        chk("sat_out_ctrl", 128'(out_ctrl), 128'(16'h5A5A));
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("drain_out_valid", 128'(out_valid), 128'(0));
        chk("drain_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("drain_out_data", 128'(out_data), 128'(sat_data));
        chk("drain_stall_cnt", 128'(stall_cnt), 128'(CNT_SAT));

        // Random traffic with occasional flush and reset.
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0), 1'($urandom()), CW'($urandom()),
                 1'($urandom()), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register with valid/ready flow control, a one-entry skid buffer, flush and bubble insertion.
- Successor to the fixed-width per-field stage registers: one instance carries a control bundle (CTRL_W) and a datapath bundle (DATA_W) between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Stalls back-pressure without dropping data.
- A saturating counter records stall cycles for performance measurement.

Parameters:
- CTRL_W, 16: width of the control bundle (RegDst, ALUOp, MemRead, RegWrite, ... packed by the instantiating stage).
- DATA_W, 101: width of the datapath bundle (e.g. rd1, rd2, immediate, write-register number).
- BUBBLE_CTRL, {CTRL_W{1'b0}}: control value presented whenever the stage holds no valid instruction. All-zero means no writes and no memory access.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: reset, synchronous, active-low (0 = reset).
- flush, input, 1: discard all held entries (branch taken or exception).
- in_valid, input, 1: upstream stage presents a valid instruction.
- in_ready, output, 1: stage can accept this cycle.
- in_ctrl, input, CTRL_W: incoming control bundle.
- in_data, input, DATA_W: incoming datapath bundle.
- out_valid, output, 1: stage holds a valid instruction.
- out_ready, input, 1: downstream stage consumes this cycle.
- out_ctrl, output, CTRL_W: registered control; equals BUBBLE_CTRL when out_valid=0.
- out_data, output, DATA_W: registered data; value don't-care when out_valid=0, but held stable.
- stall_cnt, output, CNT_W: saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage:
  - Main register (ctrl+data) drives out_ctrl/out_data directly; no combinational path from inputs to outputs.
  - Skid register holds one extra entry.
- State machine:
  - States: EMPTY (no entry), HALF (main valid), FULL (main and skid valid).
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL); depends only on state.
  - Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Transitions (flush=0):
  - EMPTY: accept -> main<=in, HALF. Otherwise stay; main ctrl holds BUBBLE_CTRL.
  - HALF, accept & consume -> main<=in, stay HALF.
  - HALF, accept & !consume -> skid<=in, FULL.
  - HALF, !accept & consume -> main ctrl<=BUBBLE_CTRL, EMPTY.
  - HALF, neither -> hold.
  - FULL (in_ready=0): consume -> main<=skid, HALF; otherwise hold.
- Ordering: strict FIFO. The skid entry is never overtaken by a new input.
- Latency: 1 cycle input-to-output when downstream is ready. Full throughput of 1 transfer/cycle in HALF.
- Flush:
  - Priority below reset, above all transitions.
  - Next state EMPTY; main ctrl<=BUBBLE_CTRL; data registers hold their value.
  - An in_valid accepted in the flush cycle is dropped.
  - A consume in the flush cycle still counts as a transfer for downstream; the stage does not re-present it.
- Reset (rst=0 at posedge):
  - state=EMPTY, out_valid=0, in_ready=1, out_ctrl=BUBBLE_CTRL, out_data=0, skid=0, stall_cnt=0.
  - Reset mid-transfer discards both entries.
- stall_cnt:
  - Increments by 1 on each posedge where out_valid & !out_ready & flush=0.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- Control bundle and data bundle are treated opaquely; no field decoding inside the block.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1, in_ctrl=16'hFFFF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0 after release.
- Streaming: out_ready=1; inject ctrl=1..8 on consecutive cycles -> out_ctrl=1..8 each appear exactly 1 cycle after acceptance. in_ready stays 1 and no bubbles appear.
- Back-pressure: send A,B, then hold out_ready=0 for 3 cycles.
  - Required: state FULL, in_ready=0, out_ctrl=A held, stall_cnt=3.
  - Release out_ready: A then B emitted in order, C accepted only after in_ready returns to 1.
- Flush while FULL with in_valid=1 (ctrl=C) -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, in_ready=1; C never appears at the output.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
- Bubble drain: single entry, out_ready=1, in_valid=0 -> out_valid drops to 0 the next cycle and out_ctrl becomes BUBBLE_CTRL while out_data is unchanged.
